// File: rtl/sar_scan_controller.sv
// Multi-channel SAR ADC scan sequencer: acquires, converts MSB-first, averages
// 2^OS_LOG2 conversions per channel and strobes the rounded result.
module sar_scan_controller #(
  parameter int WIDTH         = 12,
  parameter int CHANNELS      = 4,
  parameter int OS_LOG2       = 2,
  parameter int SAMPLE_CYCLES = 2,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic                comparator,
  output logic                sample_and_hold,
  output logic                dac_en,
  output logic [WIDTH-1:0]    dac,
  output logic [CH_W-1:0]     mux_sel,
  output logic                ack,
  output logic [WIDTH-1:0]    data,
  output logic [CH_W-1:0]     data_ch,
  output logic                busy,
  output logic [1:0]          state
);

  localparam int N      = 1 << OS_LOG2;
  localparam int ACC_W  = WIDTH + OS_LOG2;
  localparam int BIT_W  = $clog2(WIDTH);
  localparam int SC_W   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES + 1) : 1;
  localparam int CONV_W = OS_LOG2 + 1;
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'((1 << OS_LOG2) >> 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SAMPLE  = 2'b01,
    CONVERT = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    dac_q, dac_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SC_W-1:0]     samp_q, samp_d;
  logic [CONV_W-1:0]   conv_q, conv_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CH_W-1:0]     mux_q, mux_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CH_W-1:0]     data_ch_q, data_ch_d;

  logic [WIDTH-1:0]    trial_bit;
  logic [WIDTH-1:0]    resolved;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W:0]      sum_r;

  // First enabled channel strictly after cur, wrapping; cur = CHANNELS-1 yields the lowest.
  function automatic logic [CH_W-1:0] next_ch(input logic [CHANNELS-1:0] mask, input int cur);
    logic [CH_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (cur + i) % CHANNELS;
      if (!found && mask[idx[CH_W-1:0]]) begin
        sel   = CH_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dac_q     <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      conv_q    <= '0;
      acc_q     <= '0;
      mux_q     <= '0;
      data_q    <= '0;
      data_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      dac_q     <= dac_d;
      bit_q     <= bit_d;
      samp_q    <= samp_d;
      conv_q    <= conv_d;
      acc_q     <= acc_d;
      mux_q     <= mux_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dac_d     = dac_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    conv_d    = conv_q;
    acc_d     = acc_q;
    mux_d     = mux_q;
    data_d    = data_q;
    data_ch_d = data_ch_q;
    trial_bit = WIDTH'(1) << bit_q;
    resolved  = comparator ? dac_q : (dac_q & ~trial_bit);
    acc_sum   = acc_q + ACC_W'(resolved);
    sum_r     = {1'b0, acc_sum} + HALF;

    case (state_q)
      IDLE: begin
        if (!en_ && (|ch_mask)) begin
          state_d = SAMPLE;
          mux_d   = next_ch(ch_mask, CHANNELS - 1);
          samp_d  = '0;
          conv_d  = '0;
          acc_d   = '0;
        end
      end
      SAMPLE: begin
        if (en_) begin
          state_d = IDLE;
          acc_d   = '0;
        end else if (samp_q == SC_W'(SAMPLE_CYCLES - 1)) begin
          state_d = CONVERT;
          dac_d   = WIDTH'(1) << (WIDTH - 1);
          bit_d   = BIT_W'(WIDTH - 1);
        end else begin
          samp_d = samp_q + SC_W'(1);
        end
      end
      CONVERT: begin
        if (en_) begin
          state_d = IDLE;
          acc_d   = '0;
        end else if (bit_q == '0) begin
          // The rounded mean of N codes never exceeds the code range, so no clamp.
          dac_d = resolved;
          acc_d = acc_sum;
          if (conv_q == CONV_W'(N - 1)) begin
            state_d   = DONE;
            data_d    = WIDTH'(sum_r >> OS_LOG2);
            data_ch_d = mux_q;
          end else begin
            state_d = SAMPLE;
            samp_d  = '0;
            conv_d  = conv_q + CONV_W'(1);
          end
        end else begin
          dac_d = resolved | (trial_bit >> 1);
          bit_d = bit_q - BIT_W'(1);
        end
      end
      DONE: begin
        acc_d  = '0;
        conv_d = '0;
        samp_d = '0;
        if (!en_ && (|ch_mask)) begin
          state_d = SAMPLE;
          mux_d   = next_ch(ch_mask, int'(mux_q));
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ack is a single-cycle result strobe with no backpressure; data/data_ch hold until the next one.
  assign sample_and_hold = (state_q == SAMPLE);
  assign dac_en          = (state_q == CONVERT);
  assign ack             = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign dac             = dac_q;
  assign mux_sel         = mux_q;
  assign data            = data_q;
  assign data_ch         = data_ch_q;
  assign state           = state_q;

endmodule

// File: tb/tb_sar_scan_controller.sv
// Bench for sar_scan_controller: two instances (no averaging, 4x averaging) driven by
// an ideal sample-and-hold/comparator model; results checked against arithmetic expectations.
module tb_sar_scan_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc_ctr = 0;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic        en_a = 1'b1, en_b = 1'b1;
  logic [3:0]  mask_a = '0, mask_b = '0;
  logic        comp_a, comp_b;
  logic        sh_a, dac_en_a, ack_a, busy_a, sh_b, dac_en_b, ack_b, busy_b;
  logic [11:0] dac_a, data_a, dac_b, data_b;
  logic [1:0]  mux_a, data_ch_a, state_a, mux_b, data_ch_b, state_b;

  logic [11:0] ch_val_a [4];
  logic [11:0] ch_val_b [4];
  logic [11:0] held_a = '0, held_b = '0;
  logic        sh_a_prev = 1'b0, sh_b_prev = 1'b0;

  logic [11:0] exp_q [$];
  logic [1:0]  exp_ch_q [$];
  logic [11:0] last_exp_a = '0;
  logic [1:0]  last_exp_ch_a = '0;

  sar_scan_controller #(.WIDTH(12), .CHANNELS(4), .OS_LOG2(0), .SAMPLE_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .en_(en_a), .ch_mask(mask_a), .comparator(comp_a),
    .sample_and_hold(sh_a), .dac_en(dac_en_a), .dac(dac_a), .mux_sel(mux_a), .ack(ack_a),
    .data(data_a), .data_ch(data_ch_a), .busy(busy_a), .state(state_a)
  );

  sar_scan_controller #(.WIDTH(12), .CHANNELS(4), .OS_LOG2(2), .SAMPLE_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .en_(en_b), .ch_mask(mask_b), .comparator(comp_b),
    .sample_and_hold(sh_b), .dac_en(dac_en_b), .dac(dac_b), .mux_sel(mux_b), .ack(ack_b),
    .data(data_b), .data_ch(data_ch_b), .busy(busy_b), .state(state_b)
  );

  // Ideal analog front end: the selected input is frozen when acquisition starts.
  always @(negedge clk) begin
    if (sh_a && !sh_a_prev) held_a <= ch_val_a[mux_a];
    if (sh_b && !sh_b_prev) held_b <= ch_val_b[mux_b];
    sh_a_prev <= sh_a;
    sh_b_prev <= sh_b;
  end
  assign comp_a = (held_a >= dac_a);
  assign comp_b = (held_b >= dac_b);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish by 2ms");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack_a(input int budget, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = (ack_a === 1'b1);
    end
  endtask

  task automatic wait_ack_b(input int budget, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = (ack_b === 1'b1);
    end
  endtask

  task automatic go_idle_a();
    en_a = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({state_a, sh_a, dac_en_a, ack_a, busy_a} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl_a: got %b want 0", {state_a, sh_a, dac_en_a, ack_a, busy_a});
    end
    n_cmp++;
    if ({dac_a, mux_a, data_a, data_ch_a} !== 28'h0) begin
      n_fail++; $display("FAIL reset_data_a: got %h want 0", {dac_a, mux_a, data_a, data_ch_a});
    end
    n_cmp++;
    if ({state_b, sh_b, dac_en_b, ack_b, busy_b, dac_b, mux_b, data_b, data_ch_b} !== 34'h0) begin
      n_fail++; $display("FAIL reset_all_b: got %h want 0", {state_b, sh_b, dac_en_b, ack_b, busy_b, dac_b, mux_b, data_b, data_ch_b});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b%b want 00", busy_a, busy_b);
    end
  endtask

  task automatic test_single();
    bit seen;
    int t0;
    mask_a = 4'b0001;
    ch_val_a[0] = 12'hA5C;
    en_a = 1'b0;
    t0 = cyc_ctr;
    wait_ack_a(100, seen);
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL single_ack: got none want ack"); end
    n_cmp++;
    if (cyc_ctr - t0 != 15) begin n_fail++; $display("FAIL single_latency: got %0d want 15", cyc_ctr - t0); end
    n_cmp++;
    if (data_a !== 12'hA5C) begin n_fail++; $display("FAIL single_data: got %h want a5c", data_a); end
    n_cmp++;
    if (data_ch_a !== 2'd0) begin n_fail++; $display("FAIL single_ch: got %0d want 0", data_ch_a); end
    last_exp_a = 12'hA5C;
    last_exp_ch_a = 2'd0;
    en_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack_a !== 1'b0 || state_a !== 2'b00) begin
      n_fail++; $display("FAIL single_strobe: got ack=%b state=%b want ack=0 state=00", ack_a, state_a);
    end
    n_cmp++;
    if (data_a !== 12'hA5C) begin n_fail++; $display("FAIL single_hold: got %h want a5c", data_a); end
    @(negedge clk);
  endtask

  // Runs a scan with the current mask/ch_val_a; expected order is the enabled channels ascending, cyclic.
  task automatic run_scan_a(input int n_acks, input string name);
    bit  seen;
    int  t0;
    int  chans [$];
    logic [11:0] e_d;
    logic [1:0]  e_c;
    for (int c = 0; c < 4; c++) if (mask_a[c]) chans.push_back(c);
    for (int k = 0; k < n_acks; k++) begin
      exp_ch_q.push_back(2'(chans[k % chans.size()]));
      exp_q.push_back(ch_val_a[chans[k % chans.size()]]);
    end
    en_a = 1'b0;
    for (int k = 0; k < n_acks; k++) begin
      t0 = cyc_ctr;
      wait_ack_a(100, seen);
      e_d = exp_q.pop_front();
      e_c = exp_ch_q.pop_front();
      n_cmp++;
      if (!seen || (cyc_ctr - t0 != 15)) begin
        n_fail++; $display("FAIL %s_timing[%0d]: got seen=%0d cycles=%0d want 1/15", name, k, seen, cyc_ctr - t0);
      end
      n_cmp++;
      if (data_ch_a !== e_c) begin n_fail++; $display("FAIL %s_ch[%0d]: got %0d want %0d", name, k, data_ch_a, e_c); end
      n_cmp++;
      if (data_a !== e_d) begin n_fail++; $display("FAIL %s_data[%0d]: got %0d want %0d", name, k, data_a, e_d); end
      last_exp_a = e_d;
      last_exp_ch_a = e_c;
    end
    go_idle_a();
  endtask

  task automatic test_scan_order();
    mask_a = 4'b1010;
    ch_val_a[1] = 12'd100;
    ch_val_a[3] = 12'd4095;
    run_scan_a(3, "scan_order");
  endtask

  task automatic test_random_scan();
    for (int r = 0; r < 4; r++) begin
      mask_a = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) ch_val_a[c] = 12'($urandom_range(0, 4095));
      if (r == 0) for (int c = 0; c < 4; c++) if (mask_a[c]) ch_val_a[c] = 12'h000;
      run_scan_a(5, "rand_scan");
    end
  endtask

  task automatic os_round_b(input int ch, input int v0, input int v1, input int v2, input int v3, input string name);
    int  vals [4];
    int  t0, n;
    bit  seen;
    logic [11:0] e_d;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    e_d = 12'((v0 + v1 + v2 + v3 + 2) / 4);
    mask_b = 4'(1 << ch);
    ch_val_b[ch] = 12'(v0);
    en_b = 1'b0;
    t0 = cyc_ctr;
    for (int k = 1; k < 4; k++) begin
      n = 0;
      while (dac_en_b !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      ch_val_b[ch] = 12'(vals[k]);
      n = 0;
      while (dac_en_b === 1'b1 && n < 40) begin @(negedge clk); n++; end
    end
    wait_ack_b(100, seen);
    n_cmp++;
    if (!seen || (cyc_ctr - t0 != 57)) begin
      n_fail++; $display("FAIL %s_timing: got seen=%0d cycles=%0d want 1/57", name, seen, cyc_ctr - t0);
    end
    n_cmp++;
    if (data_b !== e_d) begin n_fail++; $display("FAIL %s_data: got %0d want %0d", name, data_b, e_d); end
    n_cmp++;
    if (data_ch_b !== 2'(ch)) begin n_fail++; $display("FAIL %s_ch: got %0d want %0d", name, data_ch_b, ch); end
    en_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_oversample();
    os_round_b(0, 1000, 1001, 1001, 1001, "os_fixed");
    os_round_b(3, 4095, 4095, 4095, 4095, "os_full");
    for (int r = 0; r < 3; r++)
      os_round_b($urandom_range(0, 3), $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095), "os_rand");
  endtask

  task automatic test_abort();
    int n = 0;
    int acks = 0;
    mask_a = 4'b0001;
    ch_val_a[0] = 12'h3C3;
    en_a = 1'b0;
    while (state_a !== 2'b10 && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (state_a !== 2'b00 || ack_a !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got state=%b ack=%b want 00/0", state_a, ack_a);
    end
    n_cmp++;
    if (data_a !== last_exp_a || data_ch_a !== last_exp_ch_a) begin
      n_fail++; $display("FAIL abort_hold: got %h/%0d want %h/%0d", data_a, data_ch_a, last_exp_a, last_exp_ch_a);
    end
    repeat (20) begin @(negedge clk); if (ack_a === 1'b1) acks++; end
    n_cmp++;
    if (acks != 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d want 0", acks); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit seen;
    int t0;
    mask_a = 4'b0001;
    ch_val_a[0] = 12'h7E1;
    en_a = 1'b0;
    while (state_a !== 2'b10 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({state_a, sh_a, dac_en_a, ack_a, busy_a, dac_a, mux_a, data_a, data_ch_a} !== 34'h0) begin
      n_fail++; $display("FAIL midreset_zero: got %h want 0", {state_a, sh_a, dac_en_a, ack_a, busy_a, dac_a, mux_a, data_a, data_ch_a});
    end
    ch_val_a[0] = 12'h123;
    reset = 1'b0;
    t0 = cyc_ctr;
    wait_ack_a(100, seen);
    n_cmp++;
    if (!seen || (cyc_ctr - t0 != 15)) begin
      n_fail++; $display("FAIL midreset_timing: got seen=%0d cycles=%0d want 1/15", seen, cyc_ctr - t0);
    end
    n_cmp++;
    if (data_a !== 12'h123 || data_ch_a !== 2'd0) begin
      n_fail++; $display("FAIL midreset_data: got %h/%0d want 123/0", data_a, data_ch_a);
    end
    last_exp_a = 12'h123;
    last_exp_ch_a = 2'd0;
    go_idle_a();
  endtask

  task automatic test_no_channels();
    int busy_cnt = 0;
    int ack_cnt = 0;
    mask_a = 4'b0000;
    en_a = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy_a !== 1'b0) busy_cnt++;
      if (ack_a !== 1'b0) ack_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 0) begin n_fail++; $display("FAIL nomask_busy: got %0d busy cycles want 0", busy_cnt); end
    n_cmp++;
    if (ack_cnt != 0) begin n_fail++; $display("FAIL nomask_ack: got %0d acks want 0", ack_cnt); end
    n_cmp++;
    if (data_a !== last_exp_a) begin n_fail++; $display("FAIL nomask_hold: got %h want %h", data_a, last_exp_a); end
    en_a = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      ch_val_a[c] = '0;
      ch_val_b[c] = '0;
    end
    test_reset();
    test_single();
    test_scan_order();
    test_random_scan();
    test_oversample();
    test_abort();
    test_reset_mid();
    test_no_channels();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
